// File: rtl/adc_avg_avmm_pkg.sv
// Shared constants for the ADC averaging block: register map, CTRL bit
// positions and the sample/channel widths of the AD7928 front end.
// No logic; imported by the interface-facing top and the per-channel accumulator.
package adc_pkg;

  localparam int ADC_DW  = 12;  // conversion result width
  localparam int ADC_CHW = 3;   // channel index width

  // Word addresses on the Avalon-MM slave
  localparam logic [3:0] ADDR_RESULT0  = 4'd0;
  localparam logic [3:0] ADDR_STATUS   = 4'd8;
  localparam logic [3:0] ADDR_CTRL     = 4'd9;
  localparam logic [3:0] ADDR_IRQ_MASK = 4'd10;

  // CTRL register bits
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

endpackage

// File: rtl/adc_avg_avmm_if.sv
// Avalon-MM slave bus for the ADC averager (no waitrequest, fixed read latency 1).
// Ports: avs_address/avs_read/avs_write/avs_writedata from the fabric,
//        avs_readdata/avs_readdatavalid back to the fabric.
interface adc_avg_avmm_if;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/adc_avg_avmm_ch_accum.sv
// Purpose: boxcar accumulator for one channel, 2^AVG_LOG2 samples per result.
// Latency: done is combinational with the completing sample; result updates on that edge.
// Backpressure: none; every sample pulse is absorbed, clr has priority over a sample.
// Ports: clk, rst_n (sync, active-low), smp_vld/smp_dat (gated sample), clr,
//        done (completion pulse), result (last average).
module adc_ch_accum
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smp_vld,
  input  logic [ADC_DW-1:0] smp_dat,
  input  logic              clr,
  output logic              done,
  output logic [ADC_DW-1:0] result
);

  localparam int AW = ADC_DW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  // cnt holds samples already summed; the sample arriving when cnt is at
  // CNT_LAST is the one that completes the window.
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  assign done = smp_vld && !clr && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (smp_vld) begin
      if (done) begin
        // Include the current sample; the sum cannot overflow AW bits.
        result <= ADC_DW'((acc + AW'(smp_dat)) >> AVG_LOG2);
        acc    <= '0;
        cnt    <= '0;
      end else begin
        acc <= acc + AW'(smp_dat);
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_avg_avmm.sv
// Purpose: per-channel averaging of AD7928 samples exposed on an Avalon-MM slave.
// Latency: result visible 1 cycle after the completing sample; read data 1 cycle after avs_read.
// Backpressure: none; no waitrequest, samples and bus accesses always complete.
// Ports: clk, rst_n (sync, active-low), in_vld/in_ch/in_data (sample stream),
//        avs (Avalon-MM slave modport), irq (level, new_flags & irq_mask).
module adc_avg_avmm
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 4,
  parameter int NCH      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  input  logic [ADC_CHW-1:0] in_ch,
  input  logic [ADC_DW-1:0]  in_data,
  adc_avg_avmm_if.slave      avs,
  output logic               irq
);

  logic              enable;
  logic [NCH-1:0]    irq_mask;
  logic [NCH-1:0]    new_flags;
  logic [NCH-1:0]    done_vec;
  logic [ADC_DW-1:0] result [NCH];

  logic           wr_ctrl;
  logic           wr_mask;
  logic           ch_clr;
  logic [NCH-1:0] rd_clr;
  logic [NCH-1:0] w1c_clr;
  logic [31:0]    rd_mux;
  logic           unused_wdat;

  assign unused_wdat = ^avs.avs_writedata[31:NCH];

  assign wr_ctrl = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign wr_mask = avs.avs_write && (avs.avs_address == ADDR_IRQ_MASK);
  assign ch_clr  = wr_ctrl && avs.avs_writedata[CTRL_CLEAR];

  // Flag clears from a RESULT read or a STATUS W1C; a same-edge completion
  // re-sets the flag below, so set wins.
  assign rd_clr  = (avs.avs_read && !avs.avs_address[3])
                   ? (NCH'(1) << avs.avs_address[2:0]) : '0;
  assign w1c_clr = (avs.avs_write && (avs.avs_address == ADDR_STATUS))
                   ? avs.avs_writedata[NCH-1:0] : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    adc_ch_accum #(
      .AVG_LOG2(AVG_LOG2)
    ) u_accum (
      .clk    (clk),
      .rst_n  (rst_n),
      .smp_vld(in_vld && enable && (in_ch == ADC_CHW'(g))),
      .smp_dat(in_data),
      .clr    (ch_clr),
      .done   (done_vec[g]),
      .result (result[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (!avs.avs_address[3]) begin
      rd_mux = {new_flags[avs.avs_address[2:0]], 19'b0, result[avs.avs_address[2:0]]};
    end else begin
      case (avs.avs_address)
        ADDR_STATUS:   rd_mux = 32'(new_flags);
        ADDR_CTRL:     rd_mux[CTRL_ENABLE] = enable;
        ADDR_IRQ_MASK: rd_mux = 32'(irq_mask);
        default:       rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable                <= 1'b0;
      irq_mask              <= '0;
      new_flags             <= '0;
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      if (wr_ctrl) enable <= avs.avs_writedata[CTRL_ENABLE];
      if (wr_mask) irq_mask <= avs.avs_writedata[NCH-1:0];
      new_flags <= (new_flags & ~(rd_clr | w1c_clr)) | done_vec;
      avs.avs_readdatavalid <= avs.avs_read;
      if (avs.avs_read) avs.avs_readdata <= rd_mux;
    end
  end

  assign irq = |(new_flags & irq_mask);

endmodule

// File: tb/tb_adc_avg_avmm.sv
module tb_adc_avg_avmm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic [2:0]  in_ch = '0;
  logic [11:0] in_data = '0;
  logic        irq;
  int          total = 0;
  int          bad = 0;

  adc_avg_avmm_if avs_bus();

  adc_avg_avmm #(.AVG_LOG2(4), .NCH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (in_vld),
    .in_ch  (in_ch),
    .in_data(in_data),
    .avs    (avs_bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
    avs_bus.avs_address = a;
    avs_bus.avs_writedata = d;
    avs_bus.avs_write = 1'b1;
    cyc();
    avs_bus.avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [3:0] a, output logic [31:0] d, output logic v);
    avs_bus.avs_address = a;
    avs_bus.avs_read = 1'b1;
    cyc();
    avs_bus.avs_read = 1'b0;
    d = avs_bus.avs_readdata;
    v = avs_bus.avs_readdatavalid;
  endtask

  task automatic smp(input logic [2:0] ch, input logic [11:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      in_ch = ch;
      in_data = d;
      in_vld = 1'b1;
      cyc();
      in_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    avs_bus.avs_address = '0;
    avs_bus.avs_read = 1'b0;
    avs_bus.avs_write = 1'b0;
    avs_bus.avs_writedata = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++;
    if (avs_bus.avs_readdatavalid !== 1'b0) begin
      bad++; $display("FAIL reset_rdv got=%b exp=0", avs_bus.avs_readdatavalid);
    end
    for (int a = 0; a < 16; a++) begin
      avs_rd(4'(a), d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) begin
        bad++; $display("FAIL reset_read a=%0d got=%h v=%b exp=00000000 v=1", a, d, v);
      end
    end
    smp(3'd0, 12'd5, 16);
    avs_rd(4'd0, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL disabled_drop got=%h exp=00000000", d); end
  endtask

  task automatic test_avg();
    logic [31:0] d;
    logic v;
    avs_wr(4'd9, 32'h1);
    avs_wr(4'd10, 32'h08);
    for (int i = 0; i < 16; i++) smp(3'd3, 12'(100 + i), 1);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL avg_irq_set got=%b exp=1", irq); end
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h08) begin bad++; $display("FAIL avg_status got=%h exp=00000008", d); end
    avs_rd(4'd9, d, v);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL avg_ctrl got=%h exp=00000001", d); end
    avs_rd(4'd10, d, v);
    total++;
    if (d !== 32'h08) begin bad++; $display("FAIL avg_mask got=%h exp=00000008", d); end
    avs_rd(4'd3, d, v);
    total++;
    if (d !== 32'h8000006B) begin bad++; $display("FAIL avg_result3 got=%h exp=8000006b", d); end
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL avg_status_clr got=%h exp=00000000", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL avg_irq_clr got=%b exp=0", irq); end
  endtask

  task automatic test_interleave();
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 16; i++) begin
      smp(3'd0, 12'd4095, 1);
      if (i < 15) smp(3'd7, 12'd1, 1);
    end
    avs_rd(4'd0, d, v);
    total++;
    if (d !== 32'h80000FFF) begin bad++; $display("FAIL il_result0 got=%h exp=80000fff", d); end
    avs_rd(4'd7, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL il_result7_early got=%h exp=00000000", d); end
    smp(3'd7, 12'd1, 1);
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h80) begin bad++; $display("FAIL il_status7 got=%h exp=00000080", d); end
    avs_rd(4'd7, d, v);
    total++;
    if (d !== 32'h80000001) begin bad++; $display("FAIL il_result7 got=%h exp=80000001", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    logic v;
    smp(3'd2, 12'd1000, 8);
    avs_wr(4'd9, 32'h3);
    avs_rd(4'd9, d, v);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL clr_ctrl_read got=%h exp=00000001", d); end
    smp(3'd2, 12'd50, 8);
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL clr_partial got=%h exp=00000000", d); end
    smp(3'd2, 12'd50, 8);
    avs_rd(4'd2, d, v);
    total++;
    if (d !== 32'h80000032) begin bad++; $display("FAIL clr_result2 got=%h exp=80000032", d); end
    // clear in the same cycle as the would-be completing sample
    smp(3'd2, 12'd50, 15);
    in_ch = 3'd2;
    in_data = 12'd50;
    in_vld = 1'b1;
    avs_wr(4'd9, 32'h3);
    in_vld = 1'b0;
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL clr_vs_sample got=%h exp=00000000", d); end
    smp(3'd2, 12'd20, 16);
    avs_rd(4'd2, d, v);
    total++;
    if (d !== 32'h80000014) begin bad++; $display("FAIL clr_result2b got=%h exp=80000014", d); end
  endtask

  task automatic test_simul();
    logic [31:0] d;
    logic v;
    smp(3'd5, 12'd200, 16);
    smp(3'd5, 12'd300, 15);
    in_ch = 3'd5;
    in_data = 12'd300;
    in_vld = 1'b1;
    avs_rd(4'd5, d, v);
    in_vld = 1'b0;
    total++;
    if (d !== 32'h800000C8) begin bad++; $display("FAIL sim_read_old got=%h exp=800000c8", d); end
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h20) begin bad++; $display("FAIL sim_flag_kept got=%h exp=00000020", d); end
    avs_rd(4'd5, d, v);
    total++;
    if (d !== 32'h8000012C) begin bad++; $display("FAIL sim_result5 got=%h exp=8000012c", d); end
    smp(3'd1, 12'd8, 15);
    in_ch = 3'd1;
    in_data = 12'd8;
    in_vld = 1'b1;
    avs_wr(4'd8, 32'h02);
    in_vld = 1'b0;
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h02) begin bad++; $display("FAIL sim_w1c_vs_set got=%h exp=00000002", d); end
    avs_wr(4'd8, 32'h02);
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h exp=00000000", d); end
    smp(3'd1, 12'd8, 16);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4];
    logic [3:0]  adr [4];
    logic [31:0] d;
    logic v;
    adr[0] = 4'd8;  exp_d[0] = 32'h02;
    adr[1] = 4'd9;  exp_d[1] = 32'h01;
    adr[2] = 4'd10; exp_d[2] = 32'h08;
    adr[3] = 4'd12; exp_d[3] = 32'h0;
    avs_wr(4'd12, 32'hFFFF_FFFF);
    cyc();
    total++;
    if (avs_bus.avs_readdatavalid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_rdv got=%b exp=0", avs_bus.avs_readdatavalid);
    end
    avs_bus.avs_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      avs_bus.avs_address = adr[i];
      cyc();
      total++;
      if (avs_bus.avs_readdatavalid !== 1'b1 || avs_bus.avs_readdata !== exp_d[i]) begin
        bad++;
        $display("FAIL b2b_read%0d got=%h v=%b exp=%h v=1", i, avs_bus.avs_readdata,
                 avs_bus.avs_readdatavalid, exp_d[i]);
      end
    end
    avs_bus.avs_read = 1'b0;
    cyc();
    total++;
    if (avs_bus.avs_readdatavalid !== 1'b0) begin
      bad++; $display("FAIL b2b_rdv_drop got=%b exp=0", avs_bus.avs_readdatavalid);
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq); end
    avs_wr(4'd10, 32'h02);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_unmasked got=%b exp=1", irq); end
    avs_rd(4'd1, d, v);
    total++;
    if (d !== 32'h80000008) begin bad++; $display("FAIL result1 got=%h exp=80000008", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_read got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    smp(3'd4, 12'd100, 8);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    avs_wr(4'd9, 32'h1);
    smp(3'd4, 12'd10, 8);
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rstmid_partial got=%h exp=00000000", d); end
    smp(3'd4, 12'd10, 8);
    avs_rd(4'd8, d, v);
    total++;
    if (d !== 32'h10) begin bad++; $display("FAIL rstmid_status got=%h exp=00000010", d); end
    avs_rd(4'd4, d, v);
    total++;
    if (d !== 32'h8000000A) begin bad++; $display("FAIL rstmid_result4 got=%h exp=8000000a", d); end
  endtask

  initial begin
    test_reset();
    test_avg();
    test_interleave();
    test_clear();
    test_simul();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_avg_avmm.md
Name: adc_avg_avmm

Overview:
- Downstream consumer of the AD7928 serial driver.
- Takes one 12-bit conversion result per frame, tagged with its channel number.
- Keeps a per-channel boxcar average over 2^AVG_LOG2 samples.
- Exposes the averages, new-data flags and control to the Nios/Qsys fabric through an Avalon-MM slave with fixed read latency 1.

Parameters:
- AVG_LOG2, 4, log2 of samples per average (legal range 0..6; 0 means pass-through).
- NCH, 8, number of channels (fixed by the ADC; channel index is 3 bits).

Ports:
- clk  in  1  system clock, shared with the ADC driver
- rst_n  in  1  reset, synchronous, active-low
- in_vld  in  1  one-cycle pulse: in_ch/in_data valid
- in_ch  in  3  channel of the sample
- in_data  in  12  straight-binary conversion result
- avs_address  in  4  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data valid, 1 cycle after avs_read
- irq  out  1  level interrupt: (new_flags & irq_mask) != 0

Behaviour:
- Reset (rst_n low at a clk edge), all of the following are 0:
  - accumulators, counts, results, new_flags
  - ctrl.enable, irq_mask
  - avs_readdata, avs_readdatavalid, irq
- Accumulate:
  - On in_vld with enable=1: acc[in_ch] += in_data and cnt[in_ch] += 1.
  - acc width is 12+AVG_LOG2. cnt width is AVG_LOG2+1.
- Completion:
  - When cnt[in_ch] reaches 2^AVG_LOG2 (counting the current sample), result[in_ch] <= (acc+in_data) >> AVG_LOG2 (12 bits).
  - Clear acc/cnt for that channel and set new_flags[in_ch]. All of this is in the same edge; the result is visible on the next cycle.
- AVG_LOG2=0: every sample updates result directly.
- in_vld with enable=0: sample dropped; no state change.
- Channels are independent; interleaving in any order is legal.
- Register map (word addresses):
  - 0..7: RESULT[n]. Bits [11:0] = result, bit 31 = new_flags[n], other bits 0.
  - 8: STATUS. Bits [7:0] = new_flags.
  - 9: CTRL. Bit 0 = enable (RW). Bit 1 = clear (W1, self-clearing, reads 0).
  - 10: IRQ_MASK. Bits [7:0] RW.
  - 11..15: read 0, writes ignored.
- Reads:
  - avs_readdata is registered and avs_readdatavalid pulses exactly 1 cycle after avs_read.
  - Reading RESULT[n] clears new_flags[n]. The read returns the pre-clear flag value.
- Writes:
  - Writing 1 to STATUS bit n clears new_flags[n].
  - CTRL.clear zeroes all acc/cnt (results and flags kept), in the same edge.
- Simultaneous events:
  - A completion on channel n in the same cycle as a read/W1C clearing flag n leaves the flag SET (set wins); the read returns the old result.
  - CTRL.clear coinciding with in_vld: clear wins; the sample is discarded.
- No stalls: avs_waitrequest is not provided; every access completes.
- Reads and writes asserted together: write takes effect, read is also served.
- Reset mid-accumulation discards partial sums; no result is produced.

Decomposition:
- Shared package adc_pkg holds:
  - register address constants: ADDR_RESULT0=0, ADDR_STATUS=8, ADDR_CTRL=9, ADDR_IRQ_MASK=10
  - CTRL bit indices
  - ADC_DW=12 and ADC_CHW=3
- One sub-module: adc_ch_accum, one per channel (generate loop).
  - Inputs: sample pulse, data, clear.
  - Outputs: done pulse and result.
  - The top holds flags, registers and the Avalon decode.

Test Plan:
- Reset → all reads return 0, irq=0, avs_readdatavalid=0; samples with enable=0 are ignored (RESULT0 stays 0).
- enable=1, AVG_LOG2=4, 16 samples ch3 values 100..115 → RESULT[3]=0x8000006B (107), STATUS=0x08, irq=1 with mask=0x08; read RESULT[3] → next STATUS=0x00, irq=0.
- Interleave ch0 ×16 of 4095 with ch7 ×15 of 1 → RESULT0=0x80000FFF, RESULT7 unchanged, ch7 completes on its 16th sample.
- 8 samples on ch2, write CTRL=0x3 (clear+enable), then 16 samples of 50 → RESULT[2]=50; earlier partial sum discarded.
- Read RESULT[5] in the same cycle ch5 completes → returns old value with bit31 per prior flag; STATUS bit5 remains 1 afterwards.
- Back-to-back reads addr 8,9,10,12 → readdatavalid high on 4 consecutive cycles with 1-cycle latency; addr 12 returns 0.
